// File: rtl/multi_clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Optional sync_req feature is enabled by defining MULTI_CLK_DIV_SYNC_EN.
package multi_clk_div_pkg;

  localparam int CNT_W_DEF = 24;
  localparam logic [CNT_W_DEF-1:0] DEF_DIV_DEF = 24'h989680;

  // Slot fields are sized for the largest legal configuration (16 channels, 32-bit divisor).
  localparam int PEND_CH_W  = 4;
  localparam int PEND_DIV_W = 32;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W_DEF = ch_width(4);

  typedef struct packed {
    logic                  valid;
    logic [PEND_CH_W-1:0]  ch;
    logic [PEND_DIV_W-1:0] div;
  } pend_slot_t;

endpackage

// File: rtl/multi_clk_div_if.sv
// Channel enables, divisor-update handshake and divided outputs of multi_clk_div.
// sync_req exists only when MULTI_CLK_DIV_SYNC_EN is defined.
interface multi_clk_div_if
  import multi_clk_div_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
`ifdef MULTI_CLK_DIV_SYNC_EN
  logic             sync_req;
`endif
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;

`ifdef MULTI_CLK_DIV_SYNC_EN
  modport master (output en, cfg_valid, cfg_ch, cfg_div, sync_req,
                  input  cfg_ready, clkout, tick);
  modport slave  (input  en, cfg_valid, cfg_ch, cfg_div, sync_req,
                  output cfg_ready, clkout, tick);
`else
  modport master (output en, cfg_valid, cfg_ch, cfg_div,
                  input  cfg_ready, clkout, tick);
  modport slave  (input  en, cfg_valid, cfg_ch, cfg_div,
                  output cfg_ready, clkout, tick);
`endif

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, output toggle, rise tick and divisor load port.
// The sync input exists only when MULTI_CLK_DIV_SYNC_EN is defined.
module clk_div_chan
  import multi_clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             load_ok,
  output logic             clkout,
  output logic             tick
);

  logic [CNT_W-1:0] c_reg, c_next;
  logic [CNT_W-1:0] d_reg, d_next;
  logic             clk_reg, clk_next;
  logic             tick_reg, tick_next;
  logic             stop;
  logic             wrap;

`ifdef MULTI_CLK_DIV_SYNC_EN
  assign stop = sync || !en || (d_reg == '0);
`else
  assign stop = !en || (d_reg == '0);
`endif
  assign wrap = (c_reg == d_reg - CNT_W'(1));

  // A new divisor may land whenever the counter restarts from zero anyway.
  assign load_ok = stop || wrap;

  always_comb begin
    c_next    = c_reg;
    d_next    = load ? load_div : d_reg;
    clk_next  = clk_reg;
    tick_next = 1'b0;
    if (stop) begin
      c_next   = '0;
      clk_next = 1'b0;
    end else if (wrap) begin
      c_next    = '0;
      clk_next  = ~clk_reg;
      tick_next = ~clk_reg;
    end else begin
      c_next = c_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      c_reg    <= '0;
      d_reg    <= DEF_DIV;
      clk_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      c_reg    <= c_next;
      d_reg    <= d_next;
      clk_reg  <= clk_next;
      tick_reg <= tick_next;
    end
  end

  assign clkout = clk_reg;
  assign tick   = tick_reg;

endmodule

// File: rtl/multi_clk_div.sv
// NCH independent 50%-duty clock dividers sharing one pending divisor-update slot.
// Define MULTI_CLK_DIV_SYNC_EN to add the sync_req phase-alignment input.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF)
) (
  input logic            CLK,
  input logic            RST,
  multi_clk_div_if.slave bus
);

  pend_slot_t     pend_reg, pend_next;
  logic [NCH-1:0] load;
  logic [NCH-1:0] load_ok;
  logic [NCH-1:0] clkout_w;
  logic [NCH-1:0] tick_w;
  logic           accept;
  logic           in_range;
  logic           apply_any;
  logic           unused_pend;

  assign accept    = bus.cfg_valid && !pend_reg.valid;
  assign in_range  = int'(bus.cfg_ch) < NCH;
  assign apply_any = |load;

  // Out-of-range targets complete the handshake but never occupy the slot.
  always_comb begin
    pend_next = pend_reg;
    if (apply_any) begin
      pend_next.valid = 1'b0;
    end else if (accept && in_range) begin
      pend_next.valid = 1'b1;
      pend_next.ch    = PEND_CH_W'(bus.cfg_ch);
      pend_next.div   = PEND_DIV_W'(bus.cfg_div);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign bus.cfg_ready = !pend_reg.valid;
  assign unused_pend   = ^pend_reg.div;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign load[gi] = pend_reg.valid && (pend_reg.ch == PEND_CH_W'(gi)) && load_ok[gi];

      clk_div_chan #(
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
      ) u_chan (
        .CLK     (CLK),
        .RST     (RST),
        .en      (bus.en[gi]),
`ifdef MULTI_CLK_DIV_SYNC_EN
        .sync    (bus.sync_req),
`endif
        .load    (load[gi]),
        .load_div(pend_reg.div[CNT_W-1:0]),
        .load_ok (load_ok[gi]),
        .clkout  (clkout_w[gi]),
        .tick    (tick_w[gi])
      );
    end
  endgenerate

  assign bus.clkout = clkout_w;
  assign bus.tick   = tick_w;

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed plus randomized bench for multi_clk_div against a level/period reference model.
// Exercises sync_req only when MULTI_CLK_DIV_SYNC_EN is defined.
module tb_multi_clk_div;
  import multi_clk_div_pkg::*;

  localparam int NCH   = 4;
  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] TB_DEF = 24'd5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  multi_clk_div_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  multi_clk_div #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(TB_DEF)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each channel's level is base ^ floor(n/d) parity, n = enabled edges in the segment.
  int m_n[NCH];
  int m_d[NCH];
  bit m_base[NCH];
  bit m_lvl[NCH];
  bit m_tick[NCH];
  bit p_v;
  int p_ch;
  int p_div;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_n[i] = 0; m_d[i] = int'(TB_DEF); m_base[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
    end
    p_v = 0;
  endtask

  task automatic cycle();
    bit do_sync;
    bit cleared;
    logic [NCH-1:0] ec, et;
    do_sync = 0;
    cleared = 0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    do_sync = bus.sync_req;
`endif
    if (RST) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit prev, run, apply;
        prev  = m_lvl[i];
        run   = !do_sync && bus.en[i] && (m_d[i] != 0);
        apply = p_v && (p_ch == i) && (!run || ((m_n[i] + 1) % m_d[i] == 0));
        if (!run) begin
          m_n[i] = 0; m_base[i] = 0; m_lvl[i] = 0;
        end else begin
          m_n[i]++;
          m_lvl[i] = m_base[i] ^ bit'((m_n[i] / m_d[i]) % 2);
        end
        m_tick[i] = m_lvl[i] && !prev;
        if (apply) begin
          m_d[i] = p_div; m_n[i] = 0; m_base[i] = m_lvl[i]; cleared = 1;
        end
      end
      if (cleared) p_v = 0;
      else if (bus.cfg_valid && !p_v && int'(bus.cfg_ch) < NCH) begin
        p_v = 1; p_ch = int'(bus.cfg_ch); p_div = int'(bus.cfg_div);
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_lvl[i];
      et[i] = m_tick[i];
    end
    checks++;
    assert (bus.clkout === ec) else begin
      failures++;
      $error("FAIL clkout t=%0t got=%b exp=%b", $time, bus.clkout, ec);
    end
    checks++;
    assert (bus.tick === et) else begin
      failures++;
      $error("FAIL tick t=%0t got=%b exp=%b", $time, bus.tick, et);
    end
    checks++;
    assert (bus.cfg_ready === !p_v) else begin
      failures++;
      $error("FAIL cfg_ready t=%0t got=%b exp=%b", $time, bus.cfg_ready, !p_v);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic cfg(input int ch, input int div);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_div   = CNT_W'(div);
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int guard;
    RST = 1'b1;
    bus.en = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_div = '0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    bus.sync_req = 1'b0;
`endif
    model_reset();
    run(2);
    RST = 1'b0;
    run(1);

    // ch0 div=3 while disabled, then enable
    cfg(0, 3);
    run(2);
    bus.en = 4'b0001;
    run(20);

    // ch1 div=1: CLK/2
    cfg(1, 1);
    run(2);
    bus.en = 4'b0011;
    run(10);

    // accept div=5 on ch0 at c==1, then a second request while pending
    guard = 0;
    while ((m_n[0] % 3 != 1) && guard < 20) begin cycle(); guard++; end
    checks++;
    assert (guard < 20) else begin
      failures++;
      $error("FAIL align_c1 got=%0d exp=<20", guard);
    end
    cfg(0, 5);
    bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_div = 24'd2;
    cycle();
    bus.cfg_valid = 1'b0;
    run(25);

    // ch2 div=0 enabled, then div=2
    cfg(2, 0);
    bus.en = 4'b0111;
    run(100);
    cfg(2, 2);
    run(10);

    // drop en[0] mid-high-phase, re-enable
    guard = 0;
    while (!m_lvl[0] && guard < 20) begin cycle(); guard++; end
    checks++;
    assert (guard < 20) else begin
      failures++;
      $error("FAIL find_high got=%0d exp=<20", guard);
    end
    bus.en[0] = 1'b0;
    cycle();
    bus.en[0] = 1'b1;
    run(15);

    // reset mid-operation with en held
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    run(15);

`ifdef MULTI_CLK_DIV_SYNC_EN
    cfg(0, 2);
    run(3);
    cfg(1, 4);
    run(9);
    bus.sync_req = 1'b1;
    cycle();
    bus.sync_req = 1'b0;
    run(24);
`endif

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(9) == 0) bus.en = 4'($urandom);
      bus.cfg_valid = ($urandom_range(4) == 0);
      bus.cfg_ch    = 2'($urandom_range(3));
      bus.cfg_div   = CNT_W'($urandom_range(6));
`ifdef MULTI_CLK_DIV_SYNC_EN
      bus.sync_req  = ($urandom_range(30) == 0);
`endif
      RST = ($urandom_range(150) == 0);
      cycle();
    end
    RST = 1'b0;
    bus.cfg_valid = 1'b0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    bus.sync_req = 1'b0;
`endif
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CNT_W, default 24: width of the half-period divisor and counters.
REQ-003 Parameter DEF_DIV, default 24'h989680: half-period in CLK cycles loaded into every channel at reset.
REQ-004 CLK  input  1  system clock; all logic on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 en  input  NCH  per-channel run enable.
REQ-007 cfg_valid  input  1  divisor-update request.
REQ-008 cfg_ready  output  1  update slot free; a transfer occurs when cfg_valid and cfg_ready are both high at a rising edge.
REQ-009 cfg_ch  input  max(1,$clog2(NCH))  target channel of the update.
REQ-010 cfg_div  input  CNT_W  new half-period in cycles.
REQ-011 sync_req  input  1  phase-align all channels; present only with MULTI_CLK_DIV_SYNC_EN.
REQ-012 clkout  output  NCH  registered divided clocks.
REQ-013 tick  output  NCH  registered one-cycle pulse per clkout rising transition.

Function
REQ-014 Each channel SHALL hold a counter c and an active divisor d; at each edge with en[i]=1 and d!=0: if c==d-1 then c<=0 and clkout[i]<=~clkout[i], else c<=c+1.
REQ-015 After en[i] rises, clkout[i] SHALL first go high at the d-th edge, then toggle every d cycles: period 2*d, 50% duty.
REQ-016 tick[i] SHALL be high for exactly the one cycle in which clkout[i] first reads 1 after a 0->1 toggle, and low otherwise.
REQ-017 d==1 SHALL give clkout = CLK/2 with tick every 2 cycles.
REQ-018 d==0 SHALL hold c=0, clkout[i]=0, tick[i]=0.
REQ-019 en[i]=0 SHALL force c<=0, clkout[i]<=0, tick[i]<=0 at the next edge, including mid-high-phase.
REQ-020 An accepted update SHALL be stored in a single pending slot (channel, divisor), and cfg_ready SHALL be 0 while the slot is occupied.
REQ-021 The pending divisor SHALL become d at the first half-period boundary (c==d-1 with toggle) of the target channel in a cycle after acceptance; the boundary toggle itself still occurs.
REQ-022 If the target channel has en=0 or d==0, the pending divisor SHALL be applied at the edge after acceptance.
REQ-023 The slot SHALL be freed on the same edge that applies it, so cfg_ready=1 in the following cycle.
REQ-024 Updates SHALL NOT affect channels other than cfg_ch; cfg_ch>=NCH SHALL be accepted and discarded.
REQ-025 Channels SHALL be fully independent except for the shared pending slot and sync_req.

Reset
REQ-026 On RST=1 at an edge: clkout=0, tick=0, all c=0, all d=DEF_DIV, pending slot empty.
REQ-027 cfg_ready SHALL be 1 in the first cycle after reset; RST SHALL override en, cfg_valid and sync_req.

Configuration
REQ-028 With MULTI_CLK_DIV_SYNC_EN defined, sync_req=1 SHALL set all c<=0, clkout<=0 and tick<=0 at the next edge, with priority over toggles; any pending update SHALL be applied on that same edge.
REQ-029 Without MULTI_CLK_DIV_SYNC_EN, the sync_req port and its logic SHALL be absent, and channels SHALL align only through en or RST.

Structure
REQ-030 Package multi_clk_div_pkg SHALL hold the CNT_W and DEF_DIV defaults, the channel-index width constant and the pending-slot struct typedef.
REQ-031 One sub-module clk_div_chan SHALL implement a single channel's counter, toggle, tick and load port; multi_clk_div instantiates NCH copies plus the pending-slot handshake.

Verification
REQ-032 Set NCH=4. After reset, program ch0 div=3 with ch0 disabled, then en=4'b0001 -> ready returns after 1 cycle; clkout[0] high at edge 3, period 6; tick[0] one cycle wide every 6 cycles.
REQ-033 Set ch1 div=1 and enable it -> clkout[1] toggles every cycle; tick[1] high every 2nd cycle.
REQ-034 With ch0 running at div=3, accept div=5 at c=1 -> cfg_ready=0 until the boundary; the old half-period completes in 3 cycles, then half-periods are 5; a second cfg_valid during the wait is not accepted.
REQ-035 Program ch2 div=0 with en=1 -> clkout[2]=0 and no ticks for 100 cycles; reprogram div=2 -> rises 2 cycles after the update applies.
REQ-036 Drop en[0] while clkout[0]=1 -> clkout[0]=0 next cycle; re-enable -> first rise after d cycles. Assert RST mid-operation -> all outputs 0 and d=DEF_DIV.
REQ-037 With MULTI_CLK_DIV_SYNC_EN, ch0 div=2 and ch1 div=4, pulse sync_req -> both 0 next cycle, then rise at edges 2 and 4 after sync; all rising edges align every 8 cycles.
